alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 42 ++++
 rtl/alu_arbiter_alu32.sv | 79 +++++++
 rtl/alu_arbiter.sv | 177 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - default operand/result and completion-counter widths
//   - FSM state encoding
//   - bit positions of the captured flags inside rsp_flags
//   - ALU32 op (operation class) and op1 (sub-operation) codes
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

   localparam int DEFAULT_DW = 32;
   localparam int DEFAULT_CW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Flag bit positions inside rsp_flags: {N, carryout, overflow, zero}
   localparam int FLG_Z  = 0;
   localparam int FLG_OV = 1;
   localparam int FLG_CO = 2;
   localparam int FLG_N  = 3;
   localparam int NFLAGS = 4;

   // op: operation class
   localparam logic [3:0] OP_ARITH = 4'd0;
   localparam logic [3:0] OP_LOGIC = 4'd1;
   localparam logic [3:0] OP_SHIFT = 4'd2;

   // op1: sub-operation within a class
   localparam logic [3:0] OP1_ADD = 4'd0;
   localparam logic [3:0] OP1_SUB = 4'd1;
   localparam logic [3:0] OP1_AND = 4'd0;
   localparam logic [3:0] OP1_OR  = 4'd1;
   localparam logic [3:0] OP1_XOR = 4'd2;
   localparam logic [3:0] OP1_SLL = 4'd0;
   localparam logic [3:0] OP1_SRL = 4'd1;
   localparam logic [3:0] OP1_SRA = 4'd2;

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_alu32.sv
// -----------------------------------------------------------------------------
// alu_arbiter_alu32
// Purely combinational ALU32 datapath used by alu_arbiter.
//   op_i       op class   : ARITH / LOGIC / SHIFT, anything else passes in0
//   op1_i      sub-op     : ADD/SUB, AND/OR/XOR, SLL/SRL/SRA
//   in0_i      operand A (shift source)
//   in1_i      operand B (shift amount in the low log2(DW) bits)
//   out_o      result
//   carryout_o carry out of the adder (SUB: 1 means no borrow); 0 otherwise
//   overflow_o signed overflow of ADD/SUB; 0 otherwise
//   zero_o     result is all zeros
//   n_o        result MSB
// -----------------------------------------------------------------------------
module alu_arbiter_alu32
   import alu_arbiter_pkg::*;
#(
   parameter int DW = DEFAULT_DW
) (
   input  logic [3:0]    op_i,
   input  logic [3:0]    op1_i,
   input  logic [DW-1:0] in0_i,
   input  logic [DW-1:0] in1_i,
   output logic [DW-1:0] out_o,
   output logic          carryout_o,
   output logic          overflow_o,
   output logic          zero_o,
   output logic          n_o
);

   localparam int SW = $clog2(DW);

   logic          is_sub;
   logic [DW-1:0] b_eff;
   logic [DW:0]   sum;
   logic [SW-1:0] shamt;

   // Subtraction reuses the adder as a + ~b + 1, so carry and overflow
   // come from one expression for both ADD and SUB.
   assign is_sub = (op_i == OP_ARITH) && (op1_i == OP1_SUB);
   assign b_eff  = is_sub ? ~in1_i : in1_i;
   assign sum    = {1'b0, in0_i} + {1'b0, b_eff} + {{DW{1'b0}}, is_sub};
   assign shamt  = in1_i[SW-1:0];

   // NOTE: every output of a combinational block gets a default at the top,
   // so no path through the case statements can leave one unassigned (latch).
   always_comb begin
      out_o      = in0_i;
      carryout_o = 1'b0;
      overflow_o = 1'b0;
      case (op_i)
         OP_ARITH: begin
            out_o      = sum[DW-1:0];
            carryout_o = sum[DW];
            overflow_o = (in0_i[DW-1] == b_eff[DW-1]) && (sum[DW-1] != in0_i[DW-1]);
         end
         OP_LOGIC: begin
            case (op1_i)
               OP1_AND: out_o = in0_i & in1_i;
               OP1_OR:  out_o = in0_i | in1_i;
               OP1_XOR: out_o = in0_i ^ in1_i;
               default: out_o = in0_i;
            endcase
         end
         OP_SHIFT: begin
            case (op1_i)
               OP1_SLL: out_o = in0_i << shamt;
               OP1_SRL: out_o = in0_i >> shamt;
               OP1_SRA: out_o = DW'($signed(in0_i) >>> shamt);
               default: out_o = in0_i;
            endcase
         end
         default: out_o = in0_i;
      endcase
   end

   assign zero_o = (out_o == '0);
   assign n_o    = out_o[DW-1];

endmodule : alu_arbiter_alu32

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter giving two requesters time-shared access to one ALU32.
// Each operation takes IDLE (accept) -> EXEC (compute) -> RESP (hold result
// until the granted requester takes it).
//   clk, resetn              clock; synchronous active-low reset
//   reqN_valid / reqN_ready  request handshake, N = 0,1
//   reqN_op, reqN_op1        ALU32 op class / sub-op
//   reqN_in0, reqN_in1       ALU32 operands
//   rspN_valid / rspN_ready  response handshake, N = 0,1
//   rsp_out, rsp_flags       captured result and {N, carryout, overflow, zero}
//   busy                     FSM is not IDLE
//   doneN_cnt                wrapping count of completed responses per requester
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DW = DEFAULT_DW,
   parameter int CW = DEFAULT_CW
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [3:0]        req0_op,
   input  logic [3:0]        req0_op1,
   input  logic [DW-1:0]     req0_in0,
   input  logic [DW-1:0]     req0_in1,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [3:0]        req1_op,
   input  logic [3:0]        req1_op1,
   input  logic [DW-1:0]     req1_in0,
   input  logic [DW-1:0]     req1_in1,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DW-1:0]     rsp_out,
   output logic [NFLAGS-1:0] rsp_flags,
   output logic              busy,
   output logic [CW-1:0]     done0_cnt,
   output logic [CW-1:0]     done1_cnt
);

   state_e              state_q, state_d;
   logic                last_q, last_d;     // requester granted most recently
   logic                gid_q, gid_d;       // requester owning the current op
   logic [3:0]          op_q, op_d;
   logic [3:0]          op1_q, op1_d;
   logic [DW-1:0]       in0_q, in0_d;
   logic [DW-1:0]       in1_q, in1_d;
   logic [DW-1:0]       rsp_out_q, rsp_out_d;
   logic [NFLAGS-1:0]   rsp_flags_q, rsp_flags_d;
   logic [CW-1:0]       done0_q, done0_d;
   logic [CW-1:0]       done1_q, done1_d;

   logic                grant;
   logic                rdy0, rdy1, vld0, vld1;
   logic [DW-1:0]       alu_out;
   logic                alu_co, alu_ov, alu_z, alu_n;

   // The ALU only ever sees the latched operands, so requesters may change
   // their inputs freely once accepted or while stalled.
   alu_arbiter_alu32 #(.DW(DW)) u_alu32 (
      .op_i       (op_q),
      .op1_i      (op1_q),
      .in0_i      (in0_q),
      .in1_i      (in1_q),
      .out_o      (alu_out),
      .carryout_o (alu_co),
      .overflow_o (alu_ov),
      .zero_o     (alu_z),
      .n_o        (alu_n)
   );

   // Requester 1 wins when alone, or on a tie when requester 0 was last.
   assign grant = req1_valid & (~req0_valid | ~last_q);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gid_d       = gid_q;
      op_d        = op_q;
      op1_d       = op1_q;
      in0_d       = in0_q;
      in1_d       = in1_q;
      rsp_out_d   = rsp_out_q;
      rsp_flags_d = rsp_flags_q;
      done0_d     = done0_q;
      done1_d     = done1_q;
      rdy0        = 1'b0;
      rdy1        = 1'b0;
      vld0        = 1'b0;
      vld1        = 1'b0;

      case (state_q)
         IDLE: begin
            // Handshake outputs are held low while reset is asserted so that
            // nothing can be exchanged in the reset cycle itself.
            rdy0 = resetn & req0_valid & ~grant;
            rdy1 = resetn & req1_valid &  grant;
            if (rdy0 || rdy1) begin
               gid_d   = grant;
               last_d  = grant;
               op_d    = grant ? req1_op  : req0_op;
               op1_d   = grant ? req1_op1 : req0_op1;
               in0_d   = grant ? req1_in0 : req0_in0;
               in1_d   = grant ? req1_in1 : req0_in1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_out_d             = alu_out;
            rsp_flags_d[FLG_Z]    = alu_z;
            rsp_flags_d[FLG_OV]   = alu_ov;
            rsp_flags_d[FLG_CO]   = alu_co;
            rsp_flags_d[FLG_N]    = alu_n;
            state_d               = RESP;
         end
         RESP: begin
            vld0 = resetn & ~gid_q;
            vld1 = resetn &  gid_q;
            if (vld0 && rsp0_ready) begin
               done0_d = done0_q + CW'(1);
               state_d = IDLE;
            end else if (vld1 && rsp1_ready) begin
               done1_d = done1_q + CW'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only; the reset here
   // is synchronous, so it lives inside the clocked branch, not the
   // sensitivity list.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         gid_q       <= 1'b0;
         op_q        <= '0;
         op1_q       <= '0;
         in0_q       <= '0;
         in1_q       <= '0;
         rsp_out_q   <= '0;
         rsp_flags_q <= '0;
         done0_q     <= '0;
         done1_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gid_q       <= gid_d;
         op_q        <= op_d;
         op1_q       <= op1_d;
         in0_q       <= in0_d;
         in1_q       <= in1_d;
         rsp_out_q   <= rsp_out_d;
         rsp_flags_q <= rsp_flags_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
      end
   end

   assign req0_ready = rdy0;
   assign req1_ready = rdy1;
   assign rsp0_valid = vld0;
   assign rsp1_valid = vld1;
   assign rsp_out    = rsp_out_q;
   assign rsp_flags  = rsp_flags_q;
   assign busy       = (state_q != IDLE);
   assign done0_cnt  = done0_q;
   assign done1_cnt  = done1_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter (DW=32, CW=2 so the completion counters wrap).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int DW = 32;
   localparam int CW = 2;

   // ALU encodings as used by the design
   localparam logic [3:0] ARITH = 4'd0, LOGIC = 4'd1, SHIFT = 4'd2;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1;
   localparam logic [3:0] AND_ = 4'd0, OR_ = 4'd1, XOR_ = 4'd2;
   localparam logic [3:0] SLL = 4'd0, SRL = 4'd1, SRA = 4'd2;

   logic          clk = 1'b0;
   logic          resetn;
   logic [1:0]    req_valid;
   logic [3:0]    req_op  [2];
   logic [3:0]    req_op1 [2];
   logic [DW-1:0] req_in0 [2];
   logic [DW-1:0] req_in1 [2];
   logic [1:0]    rsp_ready;
   wire  [1:0]    req_ready;
   wire  [1:0]    rsp_valid;
   wire  [DW-1:0] rsp_out;
   wire  [3:0]    rsp_flags;
   wire           busy;
   wire  [CW-1:0] done0_cnt, done1_cnt;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [CW-1:0] exp_cnt [2];

   always #5 clk = ~clk;

   alu_arbiter #(.DW(DW), .CW(CW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req0_valid (req_valid[0]),
      .req0_ready (req_ready[0]),
      .req0_op    (req_op[0]),
      .req0_op1   (req_op1[0]),
      .req0_in0   (req_in0[0]),
      .req0_in1   (req_in1[0]),
      .req1_valid (req_valid[1]),
      .req1_ready (req_ready[1]),
      .req1_op    (req_op[1]),
      .req1_op1   (req_op1[1]),
      .req1_in0   (req_in0[1]),
      .req1_in1   (req_in1[1]),
      .rsp0_valid (rsp_valid[0]),
      .rsp0_ready (rsp_ready[0]),
      .rsp1_valid (rsp_valid[1]),
      .rsp1_ready (rsp_ready[1]),
      .rsp_out    (rsp_out),
      .rsp_flags  (rsp_flags),
      .busy       (busy),
      .done0_cnt  (done0_cnt),
      .done1_cnt  (done1_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [CW-1:0] done_of(input int n);
      return (n == 0) ? done0_cnt : done1_cnt;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic present(input int n, input logic [3:0] op, input logic [3:0] op1,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_op[n]    = op;
      req_op1[n]   = op1;
      req_in0[n]   = a;
      req_in1[n]   = b;
      req_valid[n] = 1'b1;
   endtask

   // Serve one already-presented request of requester n from IDLE through
   // the response handshake. Called at a falling edge.
   task automatic serve(input int n, input int exp_wait, input int hold,
                        input logic [DW-1:0] exp_out, input logic [3:0] exp_flg,
                        input string tag);
      int o = 1 - n;
      int waited = 0;
      #1;
      while (!req_ready[n] && waited < 10) begin
         next_cycle();
         #1;
         waited++;
      end
      check($sformatf("%s_accwait", tag), 64'(waited), 64'(exp_wait));
      if (!req_ready[n]) return;
      check($sformatf("%s_other_rdy", tag), 64'(req_ready[o]), 64'd0);
      check($sformatf("%s_busy_idle", tag), 64'(busy), 64'd0);
      @(posedge clk);
      @(negedge clk);
      // Accepted: withdraw and scramble the served request; the other
      // response channel signals ready while it has nothing to deliver.
      req_valid[n] = 1'b0;
      req_op[n]    = 4'hF;
      req_op1[n]   = 4'hF;
      req_in0[n]   = 32'hDEAD_BEEF;
      req_in1[n]   = 32'h1357_9BDF;
      rsp_ready[o] = 1'b1;
      #1;
      check($sformatf("%s_exec_busy", tag), 64'(busy), 64'd1);
      check($sformatf("%s_exec_rspv", tag), 64'(rsp_valid), 64'd0);
      check($sformatf("%s_exec_rdy", tag), 64'(req_ready), 64'd0);
      next_cycle();
      #1;
      check($sformatf("%s_rspv", tag), 64'(rsp_valid), 64'(2'b01 << n));
      check($sformatf("%s_out", tag), 64'(rsp_out), 64'(exp_out));
      check($sformatf("%s_flags", tag), 64'(rsp_flags), 64'(exp_flg));
      for (int i = 0; i < hold; i++) begin
         next_cycle();
         #1;
         check($sformatf("%s_hold_v", tag), 64'(rsp_valid[n]), 64'd1);
         check($sformatf("%s_hold_out", tag), 64'(rsp_out), 64'(exp_out));
         check($sformatf("%s_hold_ordy", tag), 64'(req_ready[o]), 64'd0);
         check($sformatf("%s_hold_cnt", tag), 64'(done_of(n)), 64'(exp_cnt[n]));
      end
      rsp_ready[n] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 2'b00;
      exp_cnt[n] = exp_cnt[n] + 1'b1;
      #1;
      check($sformatf("%s_rspv_off", tag), 64'(rsp_valid), 64'd0);
      check($sformatf("%s_busy_end", tag), 64'(busy), 64'd0);
      check($sformatf("%s_cnt", tag), 64'(done_of(n)), 64'(exp_cnt[n]));
      check($sformatf("%s_ocnt", tag), 64'(done_of(o)), 64'(exp_cnt[o]));
      check($sformatf("%s_out_kept", tag), 64'(rsp_out), 64'(exp_out));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      resetn     = 1'b0;
      req_valid  = 2'b00;
      rsp_ready  = 2'b00;
      exp_cnt[0] = '0;
      exp_cnt[1] = '0;
      for (int i = 0; i < 2; i++) begin
         req_op[i] = '0; req_op1[i] = '0; req_in0[i] = '0; req_in1[i] = '0;
      end

      // Reset state, with both requests pending during reset
      repeat (3) @(negedge clk);
      req_valid = 2'b11;
      #1;
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rspv", 64'(rsp_valid), 64'd0);
      check("rst_out", 64'(rsp_out), 64'd0);
      check("rst_flags", 64'(rsp_flags), 64'd0);
      check("rst_cnt0", 64'(done0_cnt), 64'd0);
      check("rst_cnt1", 64'(done1_cnt), 64'd0);
      req_valid = 2'b00;
      next_cycle();
      resetn = 1'b1;

      // Signed overflow on add
      present(0, ARITH, ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      serve(0, 0, 0, 32'h8000_0000, 4'hA, "ovf");
      // Zero and carry
      present(0, ARITH, ADD, 32'hFFFF_FFFF, 32'h0000_0001);
      serve(0, 0, 0, 32'h0000_0000, 4'h5, "zero");
      // Subtract with borrow, single requester 1
      present(1, ARITH, SUB, 32'h0000_0005, 32'h0000_0007);
      serve(1, 0, 0, 32'hFFFF_FFFE, 4'h8, "sub");

      // Reset while a response is pending
      present(0, ARITH, ADD, 32'h0000_0001, 32'h0000_0002);
      #1;
      check("rr_acc", 64'(req_ready[0]), 64'd1);
      next_cycle();
      req_valid = 2'b00;
      next_cycle();
      #1;
      check("rr_rspv", 64'(rsp_valid), 64'd1);
      resetn = 1'b0;
      next_cycle();
      resetn = 1'b1;
      exp_cnt[0] = '0;
      exp_cnt[1] = '0;
      #1;
      check("rr_rspv_off", 64'(rsp_valid), 64'd0);
      check("rr_busy", 64'(busy), 64'd0);
      check("rr_cnt0", 64'(done0_cnt), 64'd0);
      check("rr_cnt1", 64'(done1_cnt), 64'd0);
      check("rr_out", 64'(rsp_out), 64'd0);

      // Tie straight after reset: requester 0 first, 1 in the next IDLE cycle
      present(0, LOGIC, XOR_, 32'hA5A5_A5A5, 32'hFFFF_0000);
      present(1, ARITH, ADD, 32'h0000_0001, 32'h0000_0002);
      serve(0, 0, 0, 32'h5A5A_A5A5, 4'h0, "tie1_r0");
      serve(1, 0, 0, 32'h0000_0003, 4'h0, "tie1_r1");
      // Requester 1 won last, so requester 0 wins this tie
      present(0, LOGIC, AND_, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
      present(1, SHIFT, SRA, 32'h8000_0000, 32'd4);
      serve(0, 0, 0, 32'h0000_0000, 4'h1, "tie2_r0");
      serve(1, 0, 0, 32'hF800_0000, 4'h8, "tie2_r1");
      // Requester 0 wins alone, then loses the following tie; that response
      // is back-pressured for 10 cycles with requester 0 still waiting.
      present(0, LOGIC, OR_, 32'h1234_0000, 32'h0000_5678);
      serve(0, 0, 0, 32'h1234_5678, 4'h0, "or");
      present(0, ARITH, SUB, 32'h8000_0000, 32'h0000_0001);
      present(1, SHIFT, SRL, 32'h8000_0000, 32'd31);
      serve(1, 0, 10, 32'h0000_0001, 4'h0, "bp_r1");
      serve(0, 0, 0, 32'h7FFF_FFFF, 4'h6, "bp_r0");
      // Remaining requester 1 completions walk its counter through the wrap
      present(1, SHIFT, SLL, 32'h0000_0001, 32'd31);
      serve(1, 0, 0, 32'h8000_0000, 4'h8, "sll");
      present(1, ARITH, SUB, 32'h0000_0007, 32'h0000_0007);
      serve(1, 0, 0, 32'h0000_0000, 4'h5, "sub0");
      check("wrap_cnt1", 64'(done1_cnt), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_alu_arbiter
